result_writeback_buffer: RTL and testbench

// - Write-side counterpart of the operand memory buffer. Collects N-wide result rows from the processing array

---
 rtl/sum_stationary_pkg.sv | 21 ++
 rtl/result_writeback_buffer_if.sv | 56 +++++
 rtl/result_writeback_buffer_row_store.sv | 49 ++++
 rtl/result_writeback_buffer.sv | 135 +++++++++++++
 tb/tb_result_writeback_buffer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_stationary_pkg.sv
// ----------------------------------------------------------------------------
// sum_stationary_pkg
// Shared definitions for the sum-stationary array buffers.
//   state_e : controller FSM states, common to the operand memory buffer and
//             the result writeback buffer.
//   DEFAULT_* : default array geometry and memory address width.
// ----------------------------------------------------------------------------
package sum_stationary_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_e;

  localparam int DEFAULT_DATA_WIDTH          = 32;
  localparam int DEFAULT_N                   = 4;
  localparam int DEFAULT_MEMORY_ADDRESS_BITS = 64;

endpackage

// File: rtl/result_writeback_buffer_if.sv
// ----------------------------------------------------------------------------
// result_writeback_buffer_if
// Bundles the three handshakes of the result writeback buffer:
//   address_*            : controller -> buffer, base element address
//   processor_output_*   : processing array -> buffer, one N-wide row per beat
//   memory_*             : buffer -> RAM, P elements per write beat
//   done / overflow      : status back to the controller
// Modports: slave = the buffer, master = the surrounding system.
// ----------------------------------------------------------------------------
interface result_writeback_buffer_if
  import sum_stationary_pkg::*;
#(
  parameter int DATA_WIDTH                   = DEFAULT_DATA_WIDTH,
  parameter int N                            = DEFAULT_N,
  parameter int MEMORY_ADDRESS_BITS          = DEFAULT_MEMORY_ADDRESS_BITS,
  parameter int PARALLEL_DATA_STREAMING_SIZE = 4
);

  logic                                                    address_valid;
  logic                                                    address_ready;
  logic [MEMORY_ADDRESS_BITS-1:0]                          address_input;

  logic                                                    processor_output_valid;
  logic                                                    processor_output_ready;
  logic [N-1:0][DATA_WIDTH-1:0]                            processor_output_data;
  logic                                                    processor_output_last;

  logic [MEMORY_ADDRESS_BITS-1:0]                          memory_address;
  logic                                                    memory_write_enable;
  logic                                                    memory_write_ready;
  logic [PARALLEL_DATA_STREAMING_SIZE-1:0][DATA_WIDTH-1:0] memory_write_data;

  logic                                                    done;
  logic                                                    overflow;

  modport slave (
    input  address_valid, address_input,
    output address_ready,
    input  processor_output_valid, processor_output_data, processor_output_last,
    output processor_output_ready,
    output memory_address, memory_write_enable, memory_write_data,
    input  memory_write_ready,
    output done, overflow
  );

  modport master (
    output address_valid, address_input,
    input  address_ready,
    output processor_output_valid, processor_output_data, processor_output_last,
    input  processor_output_ready,
    input  memory_address, memory_write_enable, memory_write_data,
    output memory_write_ready,
    input  done, overflow
  );

endinterface

// File: rtl/result_writeback_buffer_row_store.sv
// ----------------------------------------------------------------------------
// result_row_store
// M x N register array holding one operation's result rows, stored row-major
// (element j of row r lives at flat index r*N+j).
//   clk        : clock
//   wr_en_i    : write one full row
//   wr_row_i   : row index to write
//   wr_data_i  : row data, element j at index j
//   rd_beat_i  : memory beat index k
//   rd_data_o  : flat elements k*P .. k*P+P-1
// ----------------------------------------------------------------------------
module result_row_store #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4,
  parameter int M          = 4,
  parameter int P          = 4,
  parameter int ROW_BITS   = 3,
  parameter int BEAT_BITS  = 3
) (
  input  logic                         clk,
  input  logic                         wr_en_i,
  input  logic [ROW_BITS-1:0]          wr_row_i,
  input  logic [N-1:0][DATA_WIDTH-1:0] wr_data_i,
  input  logic [BEAT_BITS-1:0]         rd_beat_i,
  output logic [P-1:0][DATA_WIDTH-1:0] rd_data_o
);

  localparam int ENTRIES  = M * N;
  localparam int IDX_BITS = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [DATA_WIDTH-1:0] mem_q [ENTRIES];

  // NOTE: the storage array has no reset; every entry read back is written
  // earlier in the same operation, so clearing it would only cost flops.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int j = 0; j < N; j++) begin
        mem_q[IDX_BITS'(int'(wr_row_i) * N + j)] <= wr_data_i[j];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < P; p++) begin
      rd_data_o[p] = mem_q[IDX_BITS'(int'(rd_beat_i) * P + p)];
    end
  end

endmodule

// File: rtl/result_writeback_buffer.sv
// ----------------------------------------------------------------------------
// result_writeback_buffer
// Collects up to M result rows from the processing array, then writes them to
// RAM starting at a controller-supplied element address, P elements per beat,
// and pulses done when the last beat is accepted.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : result_writeback_buffer_if.slave (address, row and memory
//           handshakes plus done/overflow status)
// ----------------------------------------------------------------------------
module result_writeback_buffer
  import sum_stationary_pkg::*;
#(
  parameter int DATA_WIDTH                   = DEFAULT_DATA_WIDTH,
  parameter int N                            = DEFAULT_N,
  parameter int M                            = 4,
  parameter int MEMORY_ADDRESS_BITS          = DEFAULT_MEMORY_ADDRESS_BITS,
  parameter int PARALLEL_DATA_STREAMING_SIZE = 4,
  parameter int ROW_COUNTER_BITS             = $clog2(M + 1)
) (
  input logic                      clk,
  input logic                      reset,
  result_writeback_buffer_if.slave bus
);

  localparam int P             = PARALLEL_DATA_STREAMING_SIZE;
  localparam int BEATS_PER_ROW = N / P;
  localparam int MAX_BEATS     = M * BEATS_PER_ROW;
  localparam int BEAT_BITS     = $clog2(MAX_BEATS + 1);

  // A row must split into whole memory beats.
  if (N % P != 0) begin : g_bad_p
    $error("result_writeback_buffer: N must be a multiple of PARALLEL_DATA_STREAMING_SIZE");
  end

  state_e                         state_q;
  logic [ROW_COUNTER_BITS-1:0]    row_count_q;
  logic [ROW_COUNTER_BITS-1:0]    row_count_d;
  logic [BEAT_BITS-1:0]           beat_q;
  logic [BEAT_BITS-1:0]           last_beat_q;
  logic [MEMORY_ADDRESS_BITS-1:0] addr_q;
  logic                           row_ready_q;
  logic                           write_enable_q;
  logic                           done_q;
  logic                           overflow_q;
  logic                           row_accept;
  logic [P-1:0][DATA_WIDTH-1:0]   beat_data;

  assign row_accept  = (state_q == COLLECT) && row_ready_q && bus.processor_output_valid;
  assign row_count_d = row_count_q + ROW_COUNTER_BITS'(1);

  result_row_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .M          (M),
    .P          (P),
    .ROW_BITS   (ROW_COUNTER_BITS),
    .BEAT_BITS  (BEAT_BITS)
  ) u_row_store (
    .clk       (clk),
    .wr_en_i   (row_accept),
    .wr_row_i  (row_count_q),
    .wr_data_i (bus.processor_output_data),
    .rd_beat_i (beat_q),
    .rd_data_o (beat_data)
  );

  // NOTE: all FSM state and registered outputs update with non-blocking
  // assignments so every branch sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      row_count_q    <= '0;
      beat_q         <= '0;
      last_beat_q    <= '0;
      addr_q         <= '0;
      row_ready_q    <= 1'b0;
      write_enable_q <= 1'b0;
      done_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.address_valid && bus.address_ready) begin
            addr_q      <= bus.address_input;  // base address doubles as beat-0 address
            row_count_q <= '0;
            overflow_q  <= 1'b0;
            row_ready_q <= 1'b1;
            state_q     <= COLLECT;
          end
        end
        COLLECT: begin
          if (row_accept) begin
            row_count_q <= row_count_d;
            if (bus.processor_output_last || (row_count_d == ROW_COUNTER_BITS'(M))) begin
              // Buffer full without last means the operation overran M rows.
              overflow_q     <= !bus.processor_output_last;
              row_ready_q    <= 1'b0;
              write_enable_q <= 1'b1;
              beat_q         <= '0;
              last_beat_q    <= BEAT_BITS'(int'(row_count_d) * BEATS_PER_ROW - 1);
              state_q        <= WRITE;
            end
          end
        end
        WRITE: begin
          if (write_enable_q && bus.memory_write_ready) begin
            if (beat_q == last_beat_q) begin
              write_enable_q <= 1'b0;
              done_q         <= 1'b1;
              state_q        <= DONE;
            end else begin
              beat_q <= beat_q + BEAT_BITS'(1);
              addr_q <= addr_q + MEMORY_ADDRESS_BITS'(P);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.address_ready          = (state_q == IDLE) && !reset;
  assign bus.processor_output_ready = row_ready_q;
  assign bus.memory_address         = addr_q;
  assign bus.memory_write_enable    = write_enable_q;
  assign bus.memory_write_data      = beat_data;
  assign bus.done                   = done_q;
  assign bus.overflow               = overflow_q;

endmodule

// File: tb/tb_result_writeback_buffer.sv
module tb_result_writeback_buffer;

  localparam int DW = 32;
  localparam int AW = 64;

  typedef logic [3:0][DW-1:0] row_t;
  typedef logic [1:0][DW-1:0] beat2_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  result_writeback_buffer_if #(.DATA_WIDTH(DW), .N(4), .MEMORY_ADDRESS_BITS(AW),
                               .PARALLEL_DATA_STREAMING_SIZE(4)) b4 ();
  result_writeback_buffer_if #(.DATA_WIDTH(DW), .N(4), .MEMORY_ADDRESS_BITS(AW),
                               .PARALLEL_DATA_STREAMING_SIZE(2)) b2 ();

  result_writeback_buffer #(.DATA_WIDTH(DW), .N(4), .M(4), .MEMORY_ADDRESS_BITS(AW),
                            .PARALLEL_DATA_STREAMING_SIZE(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4));
  result_writeback_buffer #(.DATA_WIDTH(DW), .N(4), .M(4), .MEMORY_ADDRESS_BITS(AW),
                            .PARALLEL_DATA_STREAMING_SIZE(2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2));

  int checks = 0;
  int errors = 0;

  // Write-beat monitor: records every accepted beat and done pulse.
  int            cycle = 0;
  logic [AW-1:0] acc_addr4 [$];
  row_t          acc_data4 [$];
  int            acc_cyc4  [$];
  int            done_cnt4 = 0;
  int            done_cyc4 = 0;
  logic [AW-1:0] acc_addr2 [$];
  beat2_t        acc_data2 [$];
  int            done_cnt2 = 0;

  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (b4.memory_write_enable && b4.memory_write_ready) begin
      acc_addr4.push_back(b4.memory_address);
      acc_data4.push_back(b4.memory_write_data);
      acc_cyc4.push_back(cycle);
    end
    if (b4.done) begin
      done_cnt4 <= done_cnt4 + 1;
      done_cyc4 <= cycle;
    end
    if (b2.memory_write_enable && b2.memory_write_ready) begin
      acc_addr2.push_back(b2.memory_address);
      acc_data2.push_back(b2.memory_write_data);
    end
    if (b2.done) done_cnt2 <= done_cnt2 + 1;
  end

  function automatic row_t mk(input int a, input int b, input int c, input int d);
    row_t r;
    r[0] = DW'(a); r[1] = DW'(b); r[2] = DW'(c); r[3] = DW'(d);
    return r;
  endfunction

  function automatic beat2_t mk2(input int a, input int b);
    beat2_t r;
    r[0] = DW'(a); r[1] = DW'(b);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_addr4(input logic [AW-1:0] a);
    bit ok = 1'b0;
    b4.address_valid = 1'b1;
    b4.address_input = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = b4.address_ready;
      step();
    end
    b4.address_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL addr_accept: no address_ready within 20 cycles for 0x%0h", a); end
  endtask

  task automatic send_row4(input row_t d, input logic last);
    bit ok = 1'b0;
    b4.processor_output_valid = 1'b1;
    b4.processor_output_data  = d;
    b4.processor_output_last  = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = b4.processor_output_ready;
      step();
    end
    b4.processor_output_valid = 1'b0;
    b4.processor_output_last  = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL row_accept: no processor_output_ready within 20 cycles"); end
  endtask

  task automatic wait_done4(input int start_cnt);
    for (int i = 0; i < 60 && done_cnt4 == start_cnt; i++) step();
    checks++;
    if (done_cnt4 == start_cnt) begin errors++; $display("FAIL done_timeout: no done within 60 cycles"); end
  endtask

  task automatic test_reset();
    b4.address_valid = 0; b4.address_input = '0; b4.processor_output_valid = 0;
    b4.processor_output_data = '0; b4.processor_output_last = 0; b4.memory_write_ready = 1;
    b2.address_valid = 0; b2.address_input = '0; b2.processor_output_valid = 0;
    b2.processor_output_data = '0; b2.processor_output_last = 0; b2.memory_write_ready = 1;
    reset = 1'b1;
    step(); step();
    checks++; if (b4.memory_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", b4.memory_write_enable); end
    checks++; if (b4.processor_output_ready !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b want 0", b4.processor_output_ready); end
    checks++; if (b4.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", b4.done); end
    checks++; if (b4.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", b4.overflow); end
    checks++; if (b4.address_ready !== 1'b0) begin errors++; $display("FAIL reset_aready_in_reset: got %b want 0", b4.address_ready); end
    checks++; if (b2.memory_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we_p2: got %b want 0", b2.memory_write_enable); end
    reset = 1'b0;
    #1;
    checks++; if (b4.address_ready !== 1'b1) begin errors++; $display("FAIL reset_aready_after: got %b want 1", b4.address_ready); end
    checks++; if (b2.address_ready !== 1'b1) begin errors++; $display("FAIL reset_aready_after_p2: got %b want 1", b2.address_ready); end
  endtask

  task automatic test_basic();
    int a0 = acc_addr4.size();
    int d0 = done_cnt4;
    send_addr4(64'h100);
    send_row4(mk(1, 2, 3, 4), 1'b0);
    send_row4(mk(5, 6, 7, 8), 1'b1);
    wait_done4(d0);
    checks++; if (acc_addr4.size() != a0 + 2) begin errors++; $display("FAIL basic_beats: got %0d want 2", acc_addr4.size() - a0); end
    checks++; if (acc_addr4[a0] !== 64'h100) begin errors++; $display("FAIL basic_addr0: got 0x%0h want 0x100", acc_addr4[a0]); end
    checks++; if (acc_data4[a0] !== mk(1, 2, 3, 4)) begin errors++; $display("FAIL basic_data0: got 0x%0h want 0x%0h", acc_data4[a0], mk(1, 2, 3, 4)); end
    checks++; if (acc_addr4[a0+1] !== 64'h104) begin errors++; $display("FAIL basic_addr1: got 0x%0h want 0x104", acc_addr4[a0+1]); end
    checks++; if (acc_data4[a0+1] !== mk(5, 6, 7, 8)) begin errors++; $display("FAIL basic_data1: got 0x%0h want 0x%0h", acc_data4[a0+1], mk(5, 6, 7, 8)); end
    checks++; if (done_cyc4 != acc_cyc4[a0+1] + 1) begin errors++; $display("FAIL basic_done_timing: done cycle %0d, last accept cycle %0d, want +1", done_cyc4, acc_cyc4[a0+1]); end
    checks++; if (done_cnt4 != d0 + 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt4 - d0); end
    checks++; if (b4.overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b want 0", b4.overflow); end
    checks++; if (b4.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: done still %b one cycle later", b4.done); end
    checks++; if (b4.address_ready !== 1'b1) begin errors++; $display("FAIL basic_back_idle: address_ready %b want 1", b4.address_ready); end
  endtask

  task automatic test_backpressure();
    logic          pat    [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [AW-1:0] seen_a [5];
    row_t          seen_d [5];
    int a0 = acc_addr4.size();
    int d0 = done_cnt4;
    send_addr4(64'h100);
    send_row4(mk(1, 2, 3, 4), 1'b0);
    send_row4(mk(5, 6, 7, 8), 1'b1);
    for (int k = 0; k < 5; k++) begin
      b4.memory_write_ready = pat[k];
      seen_a[k] = b4.memory_address;
      seen_d[k] = b4.memory_write_data;
      step();
    end
    b4.memory_write_ready = 1'b1;
    wait_done4(d0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (seen_a[k] !== ((k < 3) ? 64'h100 : 64'h104)) begin
        errors++; $display("FAIL bp_addr_hold[%0d]: got 0x%0h want 0x%0h", k, seen_a[k], (k < 3) ? 64'h100 : 64'h104);
      end
      checks++;
      if (seen_d[k] !== ((k < 3) ? mk(1, 2, 3, 4) : mk(5, 6, 7, 8))) begin
        errors++; $display("FAIL bp_data_hold[%0d]: got 0x%0h", k, seen_d[k]);
      end
    end
    checks++; if (acc_addr4.size() != a0 + 2) begin errors++; $display("FAIL bp_beats: got %0d want 2", acc_addr4.size() - a0); end
    checks++; if (done_cnt4 != d0 + 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt4 - d0); end
    checks++; if (done_cyc4 != acc_cyc4[a0+1] + 1) begin errors++; $display("FAIL bp_done_timing: done cycle %0d, last accept cycle %0d, want +1", done_cyc4, acc_cyc4[a0+1]); end
  endtask

  task automatic test_narrow();
    bit ok;
    int a0 = acc_addr2.size();
    int d0 = done_cnt2;
    ok = 1'b0;
    b2.address_valid = 1'b1; b2.address_input = 64'h40;
    for (int i = 0; i < 20 && !ok; i++) begin ok = b2.address_ready; step(); end
    b2.address_valid = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL narrow_addr_accept: no address_ready"); end
    ok = 1'b0;
    b2.processor_output_valid = 1'b1; b2.processor_output_data = mk(9, 10, 11, 12); b2.processor_output_last = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin ok = b2.processor_output_ready; step(); end
    b2.processor_output_valid = 1'b0; b2.processor_output_last = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL narrow_row_accept: no processor_output_ready"); end
    for (int i = 0; i < 60 && done_cnt2 == d0; i++) step();
    checks++; if (done_cnt2 != d0 + 1) begin errors++; $display("FAIL narrow_done: got %0d pulses want 1", done_cnt2 - d0); end
    checks++; if (acc_addr2.size() != a0 + 2) begin errors++; $display("FAIL narrow_beats: got %0d want 2", acc_addr2.size() - a0); end
    checks++; if (acc_addr2[a0] !== 64'h40) begin errors++; $display("FAIL narrow_addr0: got 0x%0h want 0x40", acc_addr2[a0]); end
    checks++; if (acc_data2[a0] !== mk2(9, 10)) begin errors++; $display("FAIL narrow_data0: got 0x%0h want 0x%0h", acc_data2[a0], mk2(9, 10)); end
    checks++; if (acc_addr2[a0+1] !== 64'h42) begin errors++; $display("FAIL narrow_addr1: got 0x%0h want 0x42", acc_addr2[a0+1]); end
    checks++; if (acc_data2[a0+1] !== mk2(11, 12)) begin errors++; $display("FAIL narrow_data1: got 0x%0h want 0x%0h", acc_data2[a0+1], mk2(11, 12)); end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] exp_a [4] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC,
                                 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0004};
    row_t          exp_d [4];
    int a0 = acc_addr4.size();
    int d0 = done_cnt4;
    exp_d[0] = mk(1, 2, 3, 4);     exp_d[1] = mk(5, 6, 7, 8);
    exp_d[2] = mk(9, 10, 11, 12);  exp_d[3] = mk(13, 14, 15, 16);
    send_addr4(64'hFFFF_FFFF_FFFF_FFF8);
    for (int r = 0; r < 4; r++) send_row4(exp_d[r], 1'b0);
    checks++; if (b4.processor_output_ready !== 1'b0) begin errors++; $display("FAIL ovf_pready: got %b want 0 after 4th row", b4.processor_output_ready); end
    checks++; if (b4.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", b4.overflow); end
    // A fifth row offered during writeback must be ignored.
    b4.processor_output_valid = 1'b1; b4.processor_output_data = mk(99, 99, 99, 99);
    wait_done4(d0);
    b4.processor_output_valid = 1'b0;
    checks++; if (acc_addr4.size() != a0 + 4) begin errors++; $display("FAIL ovf_beats: got %0d want 4", acc_addr4.size() - a0); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (acc_addr4[a0+k] !== exp_a[k]) begin errors++; $display("FAIL ovf_addr[%0d]: got 0x%0h want 0x%0h", k, acc_addr4[a0+k], exp_a[k]); end
      checks++; if (acc_data4[a0+k] !== exp_d[k]) begin errors++; $display("FAIL ovf_data[%0d]: got 0x%0h want 0x%0h", k, acc_data4[a0+k], exp_d[k]); end
    end
    checks++; if (b4.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1 after done", b4.overflow); end
    send_addr4(64'h500);
    checks++; if (b4.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0 after new address", b4.overflow); end
    d0 = done_cnt4;
    send_row4(mk(41, 42, 43, 44), 1'b1);
    wait_done4(d0);
  endtask

  task automatic test_reset_mid_write();
    int a0 = acc_addr4.size();
    int d0 = done_cnt4;
    send_addr4(64'h200);
    send_row4(mk(1, 2, 3, 4), 1'b0);
    send_row4(mk(5, 6, 7, 8), 1'b1);
    step();                          // beat 0 accepted
    b4.memory_write_ready = 1'b0;    // beat 1 outstanding
    reset = 1'b1;
    step();
    checks++; if (b4.memory_write_enable !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %b want 0", b4.memory_write_enable); end
    reset = 1'b0;
    #1;
    checks++; if (b4.address_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_aready: got %b want 1", b4.address_ready); end
    b4.memory_write_ready = 1'b1;
    repeat (3) step();
    checks++; if (acc_addr4.size() != a0 + 1) begin errors++; $display("FAIL rst_mid_beats: got %0d want 1", acc_addr4.size() - a0); end
    checks++; if (done_cnt4 != d0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt4 - d0); end
    send_addr4(64'h600);
    send_row4(mk(31, 32, 33, 34), 1'b0);
    send_row4(mk(35, 36, 37, 38), 1'b1);
    wait_done4(d0);
    checks++; if (acc_addr4.size() != a0 + 3) begin errors++; $display("FAIL rst_fresh_beats: got %0d want 2", acc_addr4.size() - a0 - 1); end
    checks++; if (acc_addr4[a0+1] !== 64'h600) begin errors++; $display("FAIL rst_fresh_addr0: got 0x%0h want 0x600", acc_addr4[a0+1]); end
    checks++; if (acc_data4[a0+1] !== mk(31, 32, 33, 34)) begin errors++; $display("FAIL rst_fresh_data0: got 0x%0h", acc_data4[a0+1]); end
    checks++; if (acc_addr4[a0+2] !== 64'h604) begin errors++; $display("FAIL rst_fresh_addr1: got 0x%0h want 0x604", acc_addr4[a0+2]); end
    checks++; if (acc_data4[a0+2] !== mk(35, 36, 37, 38)) begin errors++; $display("FAIL rst_fresh_data1: got 0x%0h", acc_data4[a0+2]); end
  endtask

  task automatic test_gating();
    int a0 = acc_addr4.size();
    int d0 = done_cnt4;
    // Rows offered while idle.
    b4.processor_output_valid = 1'b1; b4.processor_output_data = mk(77, 77, 77, 77); b4.processor_output_last = 1'b1;
    repeat (3) step();
    checks++; if (b4.processor_output_ready !== 1'b0) begin errors++; $display("FAIL gate_idle_pready: got %b want 0", b4.processor_output_ready); end
    checks++; if (b4.address_ready !== 1'b1) begin errors++; $display("FAIL gate_idle_state: address_ready %b want 1", b4.address_ready); end
    b4.processor_output_valid = 1'b0; b4.processor_output_last = 1'b0;
    send_addr4(64'h300);
    // New address offered while collecting.
    b4.address_valid = 1'b1; b4.address_input = 64'h999;
    repeat (2) step();
    checks++; if (b4.address_ready !== 1'b0) begin errors++; $display("FAIL gate_collect_aready: got %b want 0", b4.address_ready); end
    checks++; if (b4.processor_output_ready !== 1'b1) begin errors++; $display("FAIL gate_collect_pready: got %b want 1", b4.processor_output_ready); end
    b4.address_valid = 1'b0;
    send_row4(mk(21, 22, 23, 24), 1'b1);
    // Row and address offered while writing, with memory stalled.
    b4.memory_write_ready = 1'b0;
    b4.processor_output_valid = 1'b1; b4.processor_output_data = mk(88, 88, 88, 88);
    b4.address_valid = 1'b1; b4.address_input = 64'h777;
    repeat (3) step();
    checks++; if (b4.processor_output_ready !== 1'b0) begin errors++; $display("FAIL gate_write_pready: got %b want 0", b4.processor_output_ready); end
    checks++; if (b4.address_ready !== 1'b0) begin errors++; $display("FAIL gate_write_aready: got %b want 0", b4.address_ready); end
    checks++; if (b4.memory_write_enable !== 1'b1) begin errors++; $display("FAIL gate_write_we: got %b want 1", b4.memory_write_enable); end
    checks++; if (b4.memory_address !== 64'h300) begin errors++; $display("FAIL gate_write_addr: got 0x%0h want 0x300", b4.memory_address); end
    b4.processor_output_valid = 1'b0; b4.address_valid = 1'b0;
    b4.memory_write_ready = 1'b1;
    wait_done4(d0);
    checks++; if (acc_addr4.size() != a0 + 1) begin errors++; $display("FAIL gate_beats: got %0d want 1", acc_addr4.size() - a0); end
    checks++; if (acc_addr4[a0] !== 64'h300) begin errors++; $display("FAIL gate_addr: got 0x%0h want 0x300", acc_addr4[a0]); end
    checks++; if (acc_data4[a0] !== mk(21, 22, 23, 24)) begin errors++; $display("FAIL gate_data: got 0x%0h want 0x%0h", acc_data4[a0], mk(21, 22, 23, 24)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_narrow();
    test_overflow();
    test_reset_mid_write();
    test_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
